draw_vram_arb: RTL and testbench

DRAW_VRAM_ARB -- requirements
Module: draw_vram_arb

---
 rtl/xv_pkg.sv | 38 +++
 rtl/draw_vram_arb.sv | 119 +++++++++++
 tb/tb_draw_vram_arb.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xv_pkg.sv
// Shared types and constants for the VRAM arbiter: grant encoding, VRAM
// command bundle, read latency and the fixed-priority / round-robin pick.
package xv;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2,
    GNT_DRAW = 2'd3
  } arb_grant_t;

  // Cycles from grant to read data appearing on vram_data_i.
  localparam int VRAM_RD_LAT = 2;

  typedef struct packed {
    logic        sel;
    logic        wr;
    logic [3:0]  mask;
    logic [15:0] addr;
    logic [15:0] data;
  } vram_cmd_t;

  // Video always wins; otherwise a lone requester wins; a tie between CPU and
  // draw goes to whichever the round-robin pointer currently favours.
  function automatic arb_grant_t pick_grant(input logic vid,
                                            input logic cpu,
                                            input logic draw,
                                            input logic favour_cpu);
    arb_grant_t g;
    g = GNT_NONE;
    if (vid)              g = GNT_VID;
    else if (cpu && draw) g = favour_cpu ? GNT_CPU : GNT_DRAW;
    else if (cpu)         g = GNT_CPU;
    else if (draw)        g = GNT_DRAW;
    return g;
  endfunction

endpackage

// File: rtl/draw_vram_arb.sv
// Three-way VRAM arbiter: video scanout has absolute priority, CPU and draw
// engine share the remaining slots round-robin. Grant is registered onto vram_*.
module draw_vram_arb
  import xv::*;
#(
  parameter bit CPU_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n_i,

  input  logic        vid_sel_i,
  input  logic [15:0] vid_addr_i,

  input  logic        cpu_req_i,
  input  logic        cpu_wr_i,
  input  logic [3:0]  cpu_mask_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [15:0] cpu_data_i,
  output logic        cpu_ack_o,
  output logic [15:0] cpu_rd_data_o,
  output logic        cpu_rd_valid_o,

  input  logic        draw_vram_sel_i,
  input  logic        draw_wr_i,
  input  logic [3:0]  draw_mask_i,
  input  logic [15:0] draw_addr_i,
  input  logic [15:0] draw_data_i,
  output logic        draw_oe_o,

  output logic        vram_sel_o,
  output logic        vram_wr_o,
  output logic [3:0]  vram_mask_o,
  output logic [15:0] vram_addr_o,
  output logic [15:0] vram_data_o,
  input  logic [15:0] vram_data_i
);

  arb_grant_t             grant;
  logic                   cpu_live;
  logic                   favour_cpu;
  logic                   rd_issue;
  vram_cmd_t              cmd_d;
  vram_cmd_t              cmd_q;
  logic [VRAM_RD_LAT-1:0] rd_pipe;

  // A held CPU request must not be granted again in the cycle it is acked.
  assign cpu_live = cpu_req_i & ~cpu_ack_o;
  assign grant    = pick_grant(vid_sel_i, cpu_live, draw_vram_sel_i, favour_cpu);
  assign rd_issue = (grant == GNT_CPU) & ~cpu_wr_i;

  // The draw pipeline may advance when it is served or has nothing to offer.
  assign draw_oe_o = reset_n_i & ((grant == GNT_DRAW) | ~draw_vram_sel_i);

  // NOTE: every field gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    cmd_d     = cmd_q;
    cmd_d.sel = 1'b0;
    case (grant)
      GNT_VID: begin
        cmd_d.sel  = 1'b1;
        cmd_d.wr   = 1'b0;
        cmd_d.mask = 4'b1111;
        cmd_d.addr = vid_addr_i;
      end
      GNT_CPU: begin
        cmd_d.sel  = 1'b1;
        cmd_d.wr   = cpu_wr_i;
        cmd_d.mask = cpu_mask_i;
        cmd_d.addr = cpu_addr_i;
        cmd_d.data = cpu_data_i;
      end
      GNT_DRAW: begin
        cmd_d.sel  = 1'b1;
        cmd_d.wr   = draw_wr_i;
        cmd_d.mask = draw_mask_i;
        cmd_d.addr = draw_addr_i;
        cmd_d.data = draw_data_i;
      end
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_q      <= '0;
      cpu_ack_o  <= 1'b0;
      favour_cpu <= CPU_FIRST;
    end else begin
      cmd_q     <= cmd_d;
      cpu_ack_o <= (grant == GNT_CPU);
      if (grant == GNT_CPU)       favour_cpu <= 1'b0;
      else if (grant == GNT_DRAW) favour_cpu <= 1'b1;
    end
  end

  assign vram_sel_o  = cmd_q.sel;
  assign vram_wr_o   = cmd_q.wr;
  assign vram_mask_o = cmd_q.mask;
  assign vram_addr_o = cmd_q.addr;
  assign vram_data_o = cmd_q.data;

  // Read-return tracker: one bit per in-flight CPU read, shifted each cycle;
  // the last stage marks the cycle in which vram_data_i carries the data.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_pipe        <= '0;
      cpu_rd_valid_o <= 1'b0;
      cpu_rd_data_o  <= '0;
    end else begin
      rd_pipe        <= {rd_pipe[VRAM_RD_LAT-2:0], rd_issue};
      cpu_rd_valid_o <= rd_pipe[VRAM_RD_LAT-1];
      if (rd_pipe[VRAM_RD_LAT-1]) cpu_rd_data_o <= vram_data_i;
    end
  end

endmodule

// File: tb/tb_draw_vram_arb.sv
// Bench for draw_vram_arb: directed scenarios plus a randomized run, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_draw_vram_arb;
  import xv::*;

  localparam bit CPU_FIRST = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        vid_sel_i;
  logic [15:0] vid_addr_i;
  logic        cpu_req_i, cpu_wr_i;
  logic [3:0]  cpu_mask_i;
  logic [15:0] cpu_addr_i, cpu_data_i;
  logic        cpu_ack_o, cpu_rd_valid_o;
  logic [15:0] cpu_rd_data_o;
  logic        draw_vram_sel_i, draw_wr_i;
  logic [3:0]  draw_mask_i;
  logic [15:0] draw_addr_i, draw_data_i;
  logic        draw_oe_o;
  logic        vram_sel_o, vram_wr_o;
  logic [3:0]  vram_mask_o;
  logic [15:0] vram_addr_o, vram_data_o, vram_data_i;

  draw_vram_arb #(.CPU_FIRST(CPU_FIRST)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .vid_sel_i(vid_sel_i), .vid_addr_i(vid_addr_i),
    .cpu_req_i(cpu_req_i), .cpu_wr_i(cpu_wr_i), .cpu_mask_i(cpu_mask_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_ack_o(cpu_ack_o), .cpu_rd_data_o(cpu_rd_data_o), .cpu_rd_valid_o(cpu_rd_valid_o),
    .draw_vram_sel_i(draw_vram_sel_i), .draw_wr_i(draw_wr_i), .draw_mask_i(draw_mask_i),
    .draw_addr_i(draw_addr_i), .draw_data_i(draw_data_i), .draw_oe_o(draw_oe_o),
    .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o),
    .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o), .vram_data_i(vram_data_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Behavioural model: who was served last, what the VRAM bus should show,
  // and the cycles at which pending CPU reads pick up their data.
  bit          m_last_cpu;
  bit          m_ack, m_sel, m_wr, m_rd_valid, m_oe;
  logic [3:0]  m_mask;
  logic [15:0] m_addr, m_data, m_rd_data;
  arb_grant_t  m_gnt;
  logic        obs_oe;
  int          rd_due[$];

  task automatic model_clear();
    m_last_cpu = !CPU_FIRST;
    m_ack = 0; m_sel = 0; m_wr = 0; m_rd_valid = 0; m_oe = 1;
    m_mask = '0; m_addr = '0; m_data = '0; m_rd_data = '0;
    rd_due.delete();
  endtask

  task automatic set_idle();
    vid_sel_i = 0; vid_addr_i = '0;
    cpu_req_i = 0; cpu_wr_i = 0; cpu_mask_i = '0; cpu_addr_i = '0; cpu_data_i = '0;
    draw_vram_sel_i = 0; draw_wr_i = 0; draw_mask_i = '0; draw_addr_i = '0; draw_data_i = '0;
    vram_data_i = '0;
  endtask

  function automatic arb_grant_t model_grant();
    bit cpu_wants;
    cpu_wants = cpu_req_i && !m_ack;
    if (vid_sel_i) return GNT_VID;
    if (cpu_wants && draw_vram_sel_i) return m_last_cpu ? GNT_DRAW : GNT_CPU;
    if (cpu_wants) return GNT_CPU;
    if (draw_vram_sel_i) return GNT_DRAW;
    return GNT_NONE;
  endfunction

  // Advance one clock: sample draw_oe mid-cycle, evaluate the model on the
  // current inputs, then update the expected registered outputs after the edge.
  task automatic tick();
    bit          nxt_valid;
    logic [15:0] nxt_data;
    #2;
    obs_oe    = draw_oe_o;
    m_gnt     = model_grant();
    m_oe      = (m_gnt == GNT_DRAW) || !draw_vram_sel_i;
    nxt_valid = 0;
    nxt_data  = m_rd_data;
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      void'(rd_due.pop_front());
      nxt_valid = 1;
      nxt_data  = vram_data_i;
    end
    if (m_gnt == GNT_CPU && !cpu_wr_i) rd_due.push_back(cyc + 2);
    @(posedge clk);
    #1;
    cyc++;
    m_ack = (m_gnt == GNT_CPU);
    m_sel = (m_gnt != GNT_NONE);
    case (m_gnt)
      GNT_VID:  begin m_wr = 0; m_mask = 4'hF; m_addr = vid_addr_i; end
      GNT_CPU:  begin m_wr = cpu_wr_i; m_mask = cpu_mask_i; m_addr = cpu_addr_i;
                      m_data = cpu_data_i; m_last_cpu = 1; end
      GNT_DRAW: begin m_wr = draw_wr_i; m_mask = draw_mask_i; m_addr = draw_addr_i;
                      m_data = draw_data_i; m_last_cpu = 0; end
      default: ;
    endcase
    m_rd_valid = nxt_valid;
    m_rd_data  = nxt_data;
  endtask

  task automatic do_reset();
    set_idle();
    reset_n_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n_i = 1;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  task automatic test_reset();
    set_idle();
    reset_n_i = 0;
    #3;
    n_checks++;
    if ({vram_sel_o, vram_wr_o, cpu_ack_o, cpu_rd_valid_o, vram_mask_o,
         vram_addr_o, vram_data_o, cpu_rd_data_o} !== '0)
      $display("FAIL reset_outputs got sel=%b wr=%b ack=%b rv=%b mask=%h addr=%h data=%h rd=%h want all 0",
               vram_sel_o, vram_wr_o, cpu_ack_o, cpu_rd_valid_o, vram_mask_o, vram_addr_o, vram_data_o, cpu_rd_data_o);
    else n_pass++;
    n_checks++;
    if (draw_oe_o !== 1'b0) $display("FAIL reset_draw_oe got %b want 0", draw_oe_o); else n_pass++;
    @(negedge clk) reset_n_i = 1;
    @(posedge clk);
    #1;
    model_clear();
    tick();
    n_checks++;
    if (obs_oe !== 1'b1) $display("FAIL idle_draw_oe got %b want 1", obs_oe); else n_pass++;
    n_checks++;
    if (vram_sel_o !== 1'b0) $display("FAIL idle_sel got %b want 0", vram_sel_o); else n_pass++;
  endtask

  task automatic test_vid_priority();
    logic [15:0] va;
    do_reset();
    cpu_req_i = 1; cpu_wr_i = 1; cpu_mask_i = 4'h3; cpu_addr_i = 16'h2222; cpu_data_i = 16'h1111;
    draw_vram_sel_i = 1; draw_wr_i = 1; draw_mask_i = 4'hF; draw_addr_i = 16'h3333; draw_data_i = 16'h4444;
    vid_sel_i = 1;
    for (int i = 0; i < 4; i++) begin
      va = 16'($urandom);
      vid_addr_i = va;
      tick();
      n_checks++;
      if (obs_oe !== 1'b0) $display("FAIL vid_draw_oe[%0d] got %b want 0", i, obs_oe); else n_pass++;
      n_checks++;
      if (vram_addr_o !== va) $display("FAIL vid_addr[%0d] got %h want %h", i, vram_addr_o, va); else n_pass++;
      n_checks++;
      if (cpu_ack_o !== 1'b0) $display("FAIL vid_cpu_ack[%0d] got %b want 0", i, cpu_ack_o); else n_pass++;
      n_checks++;
      if ({vram_sel_o, vram_wr_o, vram_mask_o, vram_data_o} !== {1'b1, 1'b0, 4'hF, 16'h0})
        $display("FAIL vid_read[%0d] got sel=%b wr=%b mask=%h data=%h want 1 0 f 0000",
                 i, vram_sel_o, vram_wr_o, vram_mask_o, vram_data_o);
      else n_pass++;
    end
    vid_sel_i = 0;
    tick();
    n_checks++;
    if ({cpu_ack_o, vram_addr_o} !== {1'b1, 16'h2222})
      $display("FAIL vid_ptr_kept got ack=%b addr=%h want 1 2222", cpu_ack_o, vram_addr_o);
    else n_pass++;
    set_idle();
    repeat (2) tick();
  endtask

  task automatic test_round_robin();
    bit exp_cpu;
    do_reset();
    cpu_req_i = 1; cpu_wr_i = 1; cpu_mask_i = 4'h5; cpu_addr_i = 16'hC0C0; cpu_data_i = 16'h0001;
    draw_vram_sel_i = 1; draw_wr_i = 0; draw_mask_i = 4'hA; draw_addr_i = 16'hD0D0; draw_data_i = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      exp_cpu = (i % 2 == 0);
      tick();
      n_checks++;
      if (cpu_ack_o !== exp_cpu) $display("FAIL rr_ack[%0d] got %b want %b", i, cpu_ack_o, exp_cpu); else n_pass++;
      n_checks++;
      if (vram_addr_o !== (exp_cpu ? 16'hC0C0 : 16'hD0D0))
        $display("FAIL rr_addr[%0d] got %h want %h", i, vram_addr_o, exp_cpu ? 16'hC0C0 : 16'hD0D0);
      else n_pass++;
      n_checks++;
      if (obs_oe !== !exp_cpu) $display("FAIL rr_draw_oe[%0d] got %b want %b", i, obs_oe, !exp_cpu); else n_pass++;
      n_checks++;
      if (cpu_rd_valid_o !== 1'b0) $display("FAIL rr_no_return[%0d] got %b want 0", i, cpu_rd_valid_o); else n_pass++;
    end
    set_idle();
    repeat (3) tick();
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req_i = 1; cpu_wr_i = 0; cpu_mask_i = 4'hF; cpu_addr_i = 16'h1234; cpu_data_i = 16'h0;
    vram_data_i = 16'h1111;
    tick();
    n_checks++;
    if ({cpu_ack_o, vram_sel_o, vram_wr_o, vram_addr_o, cpu_rd_valid_o} !== {1'b1, 1'b1, 1'b0, 16'h1234, 1'b0})
      $display("FAIL rd_issue got ack=%b sel=%b wr=%b addr=%h rv=%b want 1 1 0 1234 0",
               cpu_ack_o, vram_sel_o, vram_wr_o, vram_addr_o, cpu_rd_valid_o);
    else n_pass++;
    vram_data_i = 16'h2222;
    tick();
    n_checks++;
    if ({cpu_ack_o, vram_sel_o, cpu_rd_valid_o} !== 3'b000)
      $display("FAIL rd_no_regrant got ack=%b sel=%b rv=%b want 0 0 0", cpu_ack_o, vram_sel_o, cpu_rd_valid_o);
    else n_pass++;
    cpu_req_i = 0;
    vram_data_i = 16'hBEEF;
    tick();
    n_checks++;
    if ({cpu_rd_valid_o, cpu_rd_data_o} !== {1'b1, 16'hBEEF})
      $display("FAIL rd_return got rv=%b data=%h want 1 beef", cpu_rd_valid_o, cpu_rd_data_o);
    else n_pass++;
    vram_data_i = 16'h0F0F;
    tick();
    n_checks++;
    if ({cpu_rd_valid_o, cpu_rd_data_o} !== {1'b0, 16'hBEEF})
      $display("FAIL rd_hold got rv=%b data=%h want 0 beef", cpu_rd_valid_o, cpu_rd_data_o);
    else n_pass++;
  endtask

  task automatic test_reset_flush();
    cpu_req_i = 1; cpu_wr_i = 0; cpu_mask_i = 4'h7; cpu_addr_i = 16'h4321; cpu_data_i = 16'hA5A5;
    tick();
    cpu_req_i = 0;
    #2;
    reset_n_i = 0;
    #1;
    n_checks++;
    if ({vram_sel_o, cpu_ack_o, vram_addr_o} !== '0)
      $display("FAIL flush_async got sel=%b ack=%b addr=%h want 0 0 0000", vram_sel_o, cpu_ack_o, vram_addr_o);
    else n_pass++;
    n_checks++;
    if ({vram_wr_o, cpu_rd_valid_o, draw_oe_o, vram_mask_o, vram_data_o, cpu_rd_data_o} !== '0)
      $display("FAIL flush_rest got wr=%b rv=%b oe=%b mask=%h data=%h rd=%h want all 0",
               vram_wr_o, cpu_rd_valid_o, draw_oe_o, vram_mask_o, vram_data_o, cpu_rd_data_o);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n_i = 1;
    @(posedge clk);
    #1;
    model_clear();
    for (int i = 0; i < 5; i++) begin
      vram_data_i = 16'($urandom);
      tick();
      n_checks++;
      if (cpu_rd_valid_o !== 1'b0) $display("FAIL flush_no_valid[%0d] got %b want 0", i, cpu_rd_valid_o); else n_pass++;
    end
  endtask

  task automatic test_draw_stall();
    do_reset();
    draw_vram_sel_i = 1; draw_wr_i = 1; draw_mask_i = 4'b1100; draw_addr_i = 16'h0100; draw_data_i = 16'h5A5A;
    vid_sel_i = 1;
    for (int i = 0; i < 3; i++) begin
      vid_addr_i = 16'($urandom);
      tick();
      n_checks++;
      if (obs_oe !== 1'b0) $display("FAIL stall_oe[%0d] got %b want 0", i, obs_oe); else n_pass++;
      n_checks++;
      if (vram_wr_o !== 1'b0) $display("FAIL stall_no_write[%0d] got %b want 0", i, vram_wr_o); else n_pass++;
    end
    vid_sel_i = 0;
    tick();
    n_checks++;
    if (obs_oe !== 1'b1) $display("FAIL stall_release_oe got %b want 1", obs_oe); else n_pass++;
    n_checks++;
    if ({vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o} !== {1'b1, 1'b1, 4'b1100, 16'h0100, 16'h5A5A})
      $display("FAIL stall_write got sel=%b wr=%b mask=%h addr=%h data=%h want 1 1 c 0100 5a5a",
               vram_sel_o, vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o);
    else n_pass++;
    draw_vram_sel_i = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (vram_sel_o !== 1'b0) $display("FAIL stall_single[%0d] got %b want 0", i, vram_sel_o); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d[7];
    bit          exp_v, exp_ack;
    do_reset();
    cpu_wr_i = 0; cpu_mask_i = 4'hF; cpu_data_i = 16'h0;
    for (int k = 0; k < 7; k++) begin
      d[k] = 16'($urandom);
      vram_data_i = d[k];
      cpu_req_i  = (k < 3);
      cpu_addr_i = (k == 0) ? 16'h00A1 : 16'h00A2;
      tick();
      exp_ack = (k == 0 || k == 2);
      exp_v   = (k == 2 || k == 4);
      n_checks++;
      if (cpu_ack_o !== exp_ack) $display("FAIL b2b_ack[%0d] got %b want %b", k, cpu_ack_o, exp_ack); else n_pass++;
      n_checks++;
      if (cpu_rd_valid_o !== exp_v) $display("FAIL b2b_valid[%0d] got %b want %b", k, cpu_rd_valid_o, exp_v); else n_pass++;
      if (exp_v) begin
        n_checks++;
        if (cpu_rd_data_o !== d[k]) $display("FAIL b2b_data[%0d] got %h want %h", k, cpu_rd_data_o, d[k]); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      vid_sel_i   = ($urandom_range(0, 3) == 0);
      vid_addr_i  = 16'($urandom);
      vram_data_i = 16'($urandom);
      if (!cpu_req_i || m_ack) begin
        cpu_req_i  = 1'($urandom_range(0, 1));
        cpu_wr_i   = 1'($urandom_range(0, 1));
        cpu_mask_i = 4'($urandom);
        cpu_addr_i = 16'($urandom);
        cpu_data_i = 16'($urandom);
      end
      if (!draw_vram_sel_i || m_oe) begin
        draw_vram_sel_i = 1'($urandom_range(0, 1));
        draw_wr_i   = 1'($urandom_range(0, 1));
        draw_mask_i = 4'($urandom);
        draw_addr_i = 16'($urandom);
        draw_data_i = 16'($urandom);
      end
      tick();
      n_checks++;
      if (obs_oe !== m_oe) $display("FAIL rnd_oe[%0d] got %b want %b", k, obs_oe, m_oe); else n_pass++;
      n_checks++;
      if ({vram_sel_o, cpu_ack_o, cpu_rd_valid_o, cpu_rd_data_o} !== {m_sel, m_ack, m_rd_valid, m_rd_data})
        $display("FAIL rnd_ctrl[%0d] got sel=%b ack=%b rv=%b rd=%h want %b %b %b %h", k,
                 vram_sel_o, cpu_ack_o, cpu_rd_valid_o, cpu_rd_data_o, m_sel, m_ack, m_rd_valid, m_rd_data);
      else n_pass++;
      if (m_sel) begin
        n_checks++;
        if ({vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o} !== {m_wr, m_mask, m_addr, m_data})
          $display("FAIL rnd_bus[%0d] got wr=%b mask=%h addr=%h data=%h want %b %h %h %h", k,
                   vram_wr_o, vram_mask_o, vram_addr_o, vram_data_o, m_wr, m_mask, m_addr, m_data);
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_vid_priority();
    test_round_robin();
    test_cpu_read();
    test_reset_flush();
    test_draw_stall();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
